// File: rtl/sdc_escaped_bus_pkg.sv
// rtl/sdc_escaped_bus_pkg.sv - shared width and channel-indexing helpers for the escaped-bus FIFO
package sdc_escaped_bus_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int rot_w(input int nch);
    return $clog2(nch);
  endfunction

  function automatic int chan_lo(input int c, input int width);
    return c * width;
  endfunction

endpackage

// File: rtl/sdc_bus_chan_fifo.sv
// rtl/sdc_bus_chan_fifo.sv - one WIDTH x DEPTH channel FIFO with registered storage and explicit count
module sdc_bus_chan_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     push_req,
  input  logic                     pop_req,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Gating on registered full/empty keeps ready free of any pop-side path.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = push_req & ~full;
  assign pop   = pop_req & ~empty;
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end
  end

endmodule

// File: rtl/sdc_escaped_bus_fifo.sv
// rtl/sdc_escaped_bus_fifo.sv - per-channel bus FIFOs with a programmable output rotation
module sdc_escaped_bus_fifo
  import sdc_escaped_bus_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NCH*WIDTH-1:0]                a,
  input  logic [NCH-1:0]                      a_valid,
  output logic [NCH-1:0]                      a_ready,
  output logic [NCH*WIDTH-1:0]                y,
  output logic [NCH-1:0]                      y_valid,
  input  logic [NCH-1:0]                      y_ready,
  input  logic [$clog2(NCH)-1:0]              rot,
  input  logic                                rot_load,
  output logic [$clog2(NCH)-1:0]              rot_cur,
  output logic                                rot_err,
  output logic [NCH*($clog2(DEPTH)+1)-1:0]    count
);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int ROT_W = rot_w(NCH);

  logic [NCH-1:0]   fifo_full;
  logic [NCH-1:0]   fifo_empty;
  logic [NCH-1:0]   fifo_pop;
  logic [WIDTH-1:0] head_arr [NCH];
  logic             all_empty;
  logic             any_push;

  function automatic logic [ROT_W-1:0] mod_nch(input int v);
    int r;
    r = v;
    if (r >= NCH) r = r - NCH;
    return ROT_W'(r);
  endfunction

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    sdc_bus_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (a[chan_lo(c, WIDTH) +: WIDTH]),
      .push_req (a_valid[c]),
      .pop_req  (fifo_pop[c]),
      .head     (head_arr[c]),
      .count    (count[chan_lo(c, CNT_W) +: CNT_W]),
      .full     (fifo_full[c]),
      .empty    (fifo_empty[c])
    );
  end

  assign a_ready = ~fifo_full;

  // Output i reads FIFO (i + rot_cur) mod NCH; the map is a bijection so pops never collide.
  always_comb begin
    logic [ROT_W-1:0] src;
    y        = '0;
    y_valid  = '0;
    fifo_pop = '0;
    src      = '0;
    for (int i = 0; i < NCH; i++) begin
      src                     = mod_nch(i + int'(rot_cur));
      y_valid[i]              = ~fifo_empty[src];
      y[i*WIDTH +: WIDTH]     = head_arr[src];
      fifo_pop[src]           = y_ready[i] & ~fifo_empty[src];
    end
  end

  assign all_empty = &fifo_empty;
  assign any_push  = |(a_valid & a_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot_cur <= '0;
      rot_err <= 1'b0;
    end else begin
      rot_err <= 1'b0;
      if (rot_load) begin
        if (all_empty && !any_push) rot_cur <= mod_nch(int'(rot));
        else                        rot_err <= 1'b1;
      end
    end
  end

endmodule
